// File: rtl/stream_widen.sv
// Packs a one-feature-per-beat stream into STREAM_OUT_MULTIPLIER-lane words,
// buffers them in a FIFO and presents them through a show-ahead output register.
module stream_widen #(
    parameter int STREAM_WIDTH          = 8,
    parameter int STREAM_OUT_MULTIPLIER = 3,
    parameter int BUFFER_DEPTH          = 9,
    parameter int BUFFER_ACCEPT_SPACE   = 64,
    parameter int STREAM_OUT_WIDTH      = STREAM_WIDTH * STREAM_OUT_MULTIPLIER
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [STREAM_WIDTH-1:0]          stream_in,
    input  logic                             stream_in_valid,
    input  logic                             stream_in_first,
    input  logic                             stream_in_last,
    output logic                             stream_in_ready,
    output logic [STREAM_OUT_WIDTH-1:0]      stream_out,
    output logic [STREAM_OUT_MULTIPLIER-1:0] stream_out_keep,
    output logic                             stream_out_valid,
    output logic                             stream_out_first,
    output logic                             stream_out_last,
    input  logic                             stream_out_ready,
    output logic                             overflow,
    output logic                             frame_error
);

    localparam int M  = STREAM_OUT_MULTIPLIER;
    localparam int LW = $clog2(M);
    localparam int BD = BUFFER_DEPTH;
    localparam logic [BD:0] CAP       = {1'b1, {BD{1'b0}}};
    localparam logic [BD:0] ACCEPT_W  = (BD+1)'(BUFFER_ACCEPT_SPACE);
    localparam logic [LW-1:0] LAST_LN = LW'(M-1);

    typedef struct packed {
        logic [STREAM_OUT_WIDTH-1:0] data;
        logic [M-1:0]                keep;
        logic                        first;
        logic                        last;
    } word_t;

    logic [LW-1:0] lane_q, lane_d;
    word_t         acc_q, acc_d;
    word_t         q0_q, q0_d, q1_q, q1_d;
    logic          q0v_q, q0v_d, q1v_q, q1v_d;
    logic [BD:0]   wr_ptr_q, wr_ptr_d, wr_vis_q, rd_ptr_q, rd_ptr_d;
    word_t         out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          overflow_q, overflow_d;
    logic          frame_error_q, frame_error_d;
    word_t         mem_q [CAP];

    word_t         cur, new0, new1;
    logic [LW-1:0] cur_lane;
    logic          new0_v, new1_v;
    logic [BD:0]   occ, free_entries;
    logic          full, wr_en, load;

    // Packer: a first beat arriving mid-word flushes the partial word and restarts at lane 0.
    always_comb begin
        lane_d        = lane_q;
        acc_d         = acc_q;
        frame_error_d = frame_error_q;
        cur           = acc_q;
        cur_lane      = lane_q;
        new0          = '0;
        new1          = '0;
        new0_v        = 1'b0;
        new1_v        = 1'b0;
        if (stream_in_valid) begin
            if (stream_in_first && lane_q != '0) begin
                new0          = acc_q;
                new0.last     = 1'b0;
                new0_v        = 1'b1;
                frame_error_d = 1'b1;
                cur_lane      = '0;
            end
            if (cur_lane == '0) begin
                cur       = '0;
                cur.first = stream_in_first;
            end
            cur.data[cur_lane*STREAM_WIDTH +: STREAM_WIDTH] = stream_in;
            cur.keep[cur_lane] = 1'b1;
            if (cur_lane == LAST_LN || stream_in_last) begin
                cur.last = stream_in_last;
                if (new0_v) begin
                    new1   = cur;
                    new1_v = 1'b1;
                end else begin
                    new0   = cur;
                    new0_v = 1'b1;
                end
                acc_d  = '0;
                lane_d = '0;
            end else begin
                acc_d  = cur;
                lane_d = cur_lane + 1'b1;
            end
        end
    end

    // Two-entry push queue: the head is written to the FIFO every cycle it is valid.
    // A double push can only follow a beat that left lane 0, so slot 1 never overflows.
    always_comb begin
        q0_d  = '0;
        q1_d  = '0;
        q0v_d = 1'b0;
        q1v_d = 1'b0;
        if (q1v_q) begin
            q0_d  = q1_q;
            q0v_d = 1'b1;
            q1_d  = new0;
            q1v_d = new0_v;
        end else begin
            q0_d  = new0;
            q0v_d = new0_v;
            q1_d  = new1;
            q1v_d = new1_v;
        end
    end

    // The output register counts as occupied storage until its word is accepted.
    always_comb begin
        occ          = (wr_ptr_q - rd_ptr_q) + {{BD{1'b0}}, out_valid_q};
        free_entries = CAP - occ;
        full         = (occ == CAP);
        wr_en        = q0v_q && !full;
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d   = overflow_q | (q0v_q & full);
        in_ready_d   = (free_entries > ACCEPT_W);
        load         = (!out_valid_q || stream_out_ready) && (rd_ptr_q != wr_vis_q);
        rd_ptr_d     = rd_ptr_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        if (load) begin
            out_d       = mem_q[rd_ptr_q[BD-1:0]];
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_valid_q && stream_out_ready) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[BD-1:0]] <= q0_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q        <= '0;
            acc_q         <= '0;
            q0_q          <= '0;
            q1_q          <= '0;
            q0v_q         <= 1'b0;
            q1v_q         <= 1'b0;
            wr_ptr_q      <= '0;
            wr_vis_q      <= '0;
            rd_ptr_q      <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            lane_q        <= lane_d;
            acc_q         <= acc_d;
            q0_q          <= q0_d;
            q1_q          <= q1_d;
            q0v_q         <= q0v_d;
            q1v_q         <= q1v_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_vis_q      <= wr_ptr_q;
            rd_ptr_q      <= rd_ptr_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign stream_in_ready  = in_ready_q;
    assign stream_out       = out_q.data;
    assign stream_out_keep  = out_q.keep;
    assign stream_out_first = out_q.first;
    assign stream_out_last  = out_q.last;
    assign stream_out_valid = out_valid_q;
    assign overflow         = overflow_q;
    assign frame_error      = frame_error_q;

endmodule

// File: tb/tb_stream_widen.sv
// Randomised bench for stream_widen against a frame-level packing model.
module tb_stream_widen;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int OW = W * M;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  stream_in = '0;
    logic          stream_in_valid = 1'b0;
    logic          stream_in_first = 1'b0;
    logic          stream_in_last = 1'b0;
    logic          stream_in_ready;
    logic [OW-1:0] stream_out;
    logic [M-1:0]  stream_out_keep;
    logic          stream_out_valid;
    logic          stream_out_first;
    logic          stream_out_last;
    logic          stream_out_ready = 1'b0;
    logic          overflow;
    logic          frame_error;

    stream_widen #(
        .STREAM_WIDTH(W),
        .STREAM_OUT_MULTIPLIER(M),
        .BUFFER_DEPTH(9),
        .BUFFER_ACCEPT_SPACE(64)
    ) dut (
        .clk(clk), .rst(rst),
        .stream_in(stream_in), .stream_in_valid(stream_in_valid),
        .stream_in_first(stream_in_first), .stream_in_last(stream_in_last),
        .stream_in_ready(stream_in_ready),
        .stream_out(stream_out), .stream_out_keep(stream_out_keep),
        .stream_out_valid(stream_out_valid), .stream_out_first(stream_out_first),
        .stream_out_last(stream_out_last), .stream_out_ready(stream_out_ready),
        .overflow(overflow), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_acc = 0;
    int          first_valid_cyc = -1;
    logic        rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: features collected per word, emitted as {data, keep, first, last}
    logic [W-1:0]  pq[$];
    logic          pfirst = 1'b0;
    logic          fe_exp = 1'b0;
    logic [63:0]   expq[$];

    task automatic emit(input logic l);
        logic [63:0] d;
        logic [63:0] kp;
        d  = '0;
        kp = (64'd1 << pq.size()) - 64'd1;
        for (int i = 0; i < pq.size(); i++) d = d | (64'(pq[i]) << (W * i));
        expq.push_back(64'({d[OW-1:0], kp[M-1:0], pfirst, l}));
        pq.delete();
    endtask

    task automatic model_beat(input logic [W-1:0] d, input logic f, input logic l);
        if (f && pq.size() != 0) begin
            emit(1'b0);
            fe_exp = 1'b1;
        end
        if (pq.size() == 0) pfirst = f;
        pq.push_back(d);
        if (pq.size() == M || l) emit(l);
    endtask

    task automatic beat(input logic [W-1:0] d, input logic f, input logic l);
        stream_in       = d;
        stream_in_first = f;
        stream_in_last  = l;
        stream_in_valid = 1'b1;
        model_beat(d, f, l);
        @(posedge clk); #1;
        stream_in_valid = 1'b0;
        stream_in_first = 1'b0;
        stream_in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (expq.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    // Every cycle a word is shown it must equal the model's head word, which also
    // proves the fields hold stable while the consumer stalls.
    always @(negedge clk) begin
        if (rst && stream_out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = int'(cyc);
            check("word_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                check("out_word",
                      64'({stream_out, stream_out_keep, stream_out_first, stream_out_last}),
                      expq[0]);
                if (stream_out_ready) begin
                    void'(expq.pop_front());
                    n_acc++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            stream_out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int c3;
        logic f, l;

        #12;
        check("reset_outputs",
              64'({stream_out_valid, stream_out, stream_out_keep, stream_out_first,
                   stream_out_last, overflow, frame_error, stream_in_ready}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(3);
        check("in_ready_after_reset", 64'(stream_in_ready), 64'd1);

        // Two full words, latency from the completing beat
        stream_out_ready = 1'b1;
        first_valid_cyc  = -1;
        c3 = 0;
        for (int i = 1; i <= 6; i++) begin
            beat(W'(i), i == 1, i == 6);
            if (i == 3) c3 = int'(cyc);
        end
        drain(50);
        check("first_valid_latency", 64'(first_valid_cyc - c3), 64'd3);

        // Early last leaves a single-lane word
        beat(8'h0A, 1'b1, 1'b0);
        beat(8'h0B, 1'b0, 1'b0);
        beat(8'h0C, 1'b0, 1'b0);
        beat(8'h0D, 1'b0, 1'b1);
        drain(50);
        check("frame_error_clear", 64'(frame_error), 64'd0);

        // first on the second lane of a word
        beat(8'h11, 1'b1, 1'b0);
        beat(8'h22, 1'b1, 1'b0);
        beat(8'h33, 1'b0, 1'b0);
        beat(8'h44, 1'b0, 1'b1);
        drain(50);
        check("frame_error_set", 64'(frame_error), 64'(fe_exp));

        // first+last on a beat that also interrupts a partial word: two pushes
        beat(8'h55, 1'b1, 1'b0);
        beat(8'h66, 1'b1, 1'b1);
        beat(8'h77, 1'b1, 1'b1);
        drain(50);

        // Random traffic with a randomly stalling consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            f = (i == 0) || ($urandom_range(0, 7) == 0);
            l = (i == 299) || ($urandom_range(0, 7) == 0);
            beat(W'($urandom), f, l);
        end
        drain(3000);
        rnd_ready = 1'b0;
        idle(2);
        stream_out_ready = 1'b1;
        check("frame_error_random", 64'(frame_error), 64'(fe_exp));

        // Fill the buffer with the consumer stalled
        stream_out_ready = 1'b0;
        idle(2);
        for (int k = 0; k < 1536; k++) begin
            beat(W'($urandom), k == 0, k == 1535);
            if (k == 447 * 3 - 1) begin
                idle(4);
                check("in_ready_free65", 64'(stream_in_ready), 64'd1);
            end
            if (k == 448 * 3 - 1) begin
                idle(4);
                check("in_ready_free64", 64'(stream_in_ready), 64'd0);
            end
        end
        idle(6);
        check("overflow_at_full", 64'(overflow), 64'd0);
        beat(8'hA1, 1'b1, 1'b0);
        beat(8'hA2, 1'b0, 1'b0);
        beat(8'hA3, 1'b0, 1'b1);
        void'(expq.pop_back());
        idle(6);
        check("overflow_set", 64'(overflow), 64'd1);
        check("in_ready_full", 64'(stream_in_ready), 64'd0);
        n_acc = 0;
        stream_out_ready = 1'b1;
        drain(2000);
        idle(10);
        check("fill_word_count", 64'(n_acc), 64'd512);

        // Asynchronous reset with buffered words and a partial word pending
        stream_out_ready = 1'b0;
        for (int k = 0; k < 17; k++) beat(W'($urandom), k == 0, 1'b0);
        idle(8);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({stream_out_valid, stream_out, stream_out_keep, stream_out_first,
                   stream_out_last, overflow, frame_error, stream_in_ready}), 64'd0);
        expq.delete();
        pq.delete();
        fe_exp = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(3);
        stream_out_ready = 1'b1;
        n_acc = 0;
        beat(8'hC1, 1'b1, 1'b0);
        beat(8'hC2, 1'b0, 1'b0);
        beat(8'hC3, 1'b0, 1'b1);
        drain(50);
        idle(20);
        check("post_reset_word_count", 64'(n_acc), 64'd1);
        check("post_reset_flags", 64'({overflow, frame_error}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
